// File: rtl/game_round_controller.sv
// -----------------------------------------------------------------------------
// game_round_controller
//
// Purpose:
//   Sequences one multiplayer snake round through IDLE -> COUNTDOWN -> RUN ->
//   OVER. It derives all game timing from the single system clock: per-snake
//   move pulses (with optional double-speed boost), the collision-check
//   strobe, and the start-of-round grace window. It also latches deaths
//   reported by collision detection and declares the winner.
//
// Ports:
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-low reset
//   start        in   1  level; begins a round from IDLE or restarts from OVER
//   pause        in   1  level; freezes RUN timing
//   dead         in   3  dead[i] from collision detection for snake i+1
//   boost        in   3  boost[i] doubles the move rate of snake i+1
//   move_en      out  3  one-cycle move pulse per snake
//   collision_en out  1  one-cycle collision-check strobe
//   grace        out  3  grace-period flag per snake (all bits equal)
//   alive        out  3  sticky alive flags
//   round_rst    out  1  one-cycle pulse that reinitialises the snake bodies
//   state        out  2  IDLE=0, COUNTDOWN=1, RUN=2, OVER=3
//   winner       out  2  0 = none/draw, 1..3 = surviving snake
// -----------------------------------------------------------------------------
module game_round_controller #(
    parameter int TICK_DIV        = 6250000,
    parameter int COUNTDOWN_TICKS = 24,
    parameter int GRACE_TICKS     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic [2:0] dead,
    input  logic [2:0] boost,
    output logic [2:0] move_en,
    output logic       collision_en,
    output logic [2:0] grace,
    output logic [2:0] alive,
    output logic       round_rst,
    output logic [1:0] state,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        RUN       = 2'd2,
        OVER      = 2'd3
    } state_t;

    localparam int CW   = $clog2(TICK_DIV);
    localparam int CDW  = $clog2(COUNTDOWN_TICKS + 1);
    localparam int GW   = $clog2(GRACE_TICKS + 2);

    localparam logic [CW-1:0]  BASE_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(TICK_DIV / 2 - 1);
    localparam logic [CDW-1:0] CD_LAST   = CDW'(COUNTDOWN_TICKS - 1);
    localparam logic [GW-1:0]  GRACE_LOAD = GW'(GRACE_TICKS);

    state_t         cur_state;
    state_t         next_state;
    logic [CW-1:0]  tick_cnt;
    logic [CDW-1:0] cd_cnt;
    logic [GW-1:0]  grace_cnt;
    logic           counting;
    logic           enter_countdown;
    logic           enter_run;
    logic           base_tick;
    logic           half_tick;
    logic [1:0]     alive_count;

    assign base_tick   = (tick_cnt == BASE_LAST);
    assign half_tick   = (tick_cnt == HALF_LAST);
    assign alive_count = {1'b0, alive[0]} + {1'b0, alive[1]} + {1'b0, alive[2]};
    assign state       = cur_state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state and combinational outputs. The round ends on the registered
    // alive count, so the survivor may still get a move pulse in that last
    // RUN cycle; its collision strobe is suppressed because OVER follows.
    always_comb begin
        next_state      = cur_state;
        counting        = 1'b0;
        enter_countdown = 1'b0;
        enter_run       = 1'b0;
        move_en         = 3'b000;
        case (cur_state)
            IDLE: begin
                if (start) begin
                    next_state      = COUNTDOWN;
                    enter_countdown = 1'b1;
                end
            end
            COUNTDOWN: begin
                counting = 1'b1;
                if (base_tick && (cd_cnt == CD_LAST)) begin
                    next_state = RUN;
                    enter_run  = 1'b1;
                end
            end
            RUN: begin
                if (alive_count <= 2'd1) begin
                    next_state = OVER;
                end
                if (!pause) begin
                    counting = 1'b1;
                    move_en  = alive & ({3{base_tick}} | (boost & {3{half_tick}}));
                end
            end
            OVER: begin
                if (start) begin
                    next_state      = COUNTDOWN;
                    enter_countdown = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Timing counters, grace window, death latch and winner. The grace flag
    // drops on the base tick that exhausts the grace counter, so deaths are
    // honoured from the following cycle onward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt     <= '0;
            cd_cnt       <= '0;
            grace_cnt    <= '0;
            grace        <= 3'b000;
            alive        <= 3'b111;
            winner       <= 2'd0;
            round_rst    <= 1'b0;
            collision_en <= 1'b0;
        end else begin
            round_rst    <= enter_countdown;
            collision_en <= (|move_en) && (next_state == RUN);

            if (enter_countdown) begin
                tick_cnt <= '0;
                cd_cnt   <= '0;
            end else if (counting) begin
                tick_cnt <= base_tick ? '0 : tick_cnt + CW'(1);
                if ((cur_state == COUNTDOWN) && base_tick) begin
                    cd_cnt <= enter_run ? '0 : cd_cnt + CDW'(1);
                end
            end

            if (enter_run) begin
                grace     <= 3'b111;
                grace_cnt <= GRACE_LOAD;
            end else if ((cur_state == RUN) && counting && base_tick) begin
                if (grace_cnt != '0) begin
                    grace_cnt <= grace_cnt - GW'(1);
                end
                if (grace_cnt <= GW'(1)) begin
                    grace <= 3'b000;
                end
            end

            if (enter_countdown) begin
                alive  <= 3'b111;
                winner <= 2'd0;
            end else if (cur_state == RUN) begin
                if (grace == 3'b000) begin
                    alive <= alive & ~dead;
                end
                if (next_state == OVER) begin
                    if (alive[0]) begin
                        winner <= 2'd1;
                    end else if (alive[1]) begin
                        winner <= 2'd2;
                    end else if (alive[2]) begin
                        winner <= 2'd3;
                    end else begin
                        winner <= 2'd0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
- Sequences a multiplayer snake round: idle, countdown, run, round-over.
- Generates per-snake move-enable pulses from one system clock, with an optional double-speed boost per snake.
- Generates the collision-check strobe and the start-of-round grace window.
- Latches deaths reported by collision detection and declares the winner.
- Sits between the game space / collision logic and the top level; replaces the free-running moveclk/collisionclk sources.

Parameters:
- TICK_DIV, 6250000: system clocks per base move tick. Must be even and at least 4.
- COUNTDOWN_TICKS, 24: base ticks spent in COUNTDOWN before RUN.
- GRACE_TICKS, 4: base ticks after RUN entry during which deaths are ignored.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; begins or restarts a round.
- pause  in  1  level; freezes RUN.
- dead  in  3  dead[i] from collision detection for snake i+1.
- boost  in  3  boost[i] doubles snake i+1 move rate.
- move_en  out  3  one-cycle move pulse per snake.
- collision_en  out  1  one-cycle collision-check strobe.
- grace  out  3  grace-period flag per snake (all bits equal).
- alive  out  3  sticky alive flags.
- round_rst  out  1  one-cycle pulse that reinitialises the snake bodies.
- state  out  2  IDLE=0, COUNTDOWN=1, RUN=2, OVER=3.
- winner  out  2  0 = none/draw, 1..3 = surviving snake.

Behaviour:
- Reset (async, reset=0): state=IDLE, tick counter=0, move_en=0, collision_en=0, grace=000, alive=111, winner=0, round_rst=0. Reset mid-round aborts immediately with the same values.
- Tick counter:
  - Width $clog2(TICK_DIV).
  - Counts only in COUNTDOWN, and in RUN while pause=0.
  - Wraps TICK_DIV-1 -> 0.
  - base tick = counter==TICK_DIV-1; half tick = counter==TICK_DIV/2-1.
  - Cleared to 0 on every entry to COUNTDOWN.
- IDLE: start=1 -> COUNTDOWN.
- OVER: start=1 -> COUNTDOWN. On that transition alive<=111 and winner<=0.
- COUNTDOWN:
  - round_rst=1 on its first cycle only.
  - Never asserts move_en.
  - On the COUNTDOWN_TICKS-th base tick -> RUN; the counter wraps to 0 and grace<=111.
  - Grace down-counter loads GRACE_TICKS.
- RUN:
  - start is ignored.
  - move_en[i]=1 for one cycle on a base tick when alive[i]=1.
  - move_en[i] is also 1 on a half tick when alive[i]=1 and boost[i]=1.
  - The first base-tick pulse comes TICK_DIV cycles after RUN entry.
  - collision_en is registered: high exactly one cycle after any cycle with move_en!=0.
  - Grace counter decrements on each base tick; grace<=000 the cycle after it reaches 0.
  - Death latch: alive[i]<=0 on any RUN cycle with dead[i]=1 and grace=000. It stays 0 until the next round. dead is ignored outside RUN.
- End of round: when the count of set alive bits (registered value) is 1 or less -> OVER, the cycle after the last clear.
  - Exactly one bit set: winner = its index+1.
  - No bits set (simultaneous deaths): winner = 0.
- pause=1 in RUN:
  - Counter and grace counter hold; no move_en.
  - collision_en may still fire once for a move pulse from the previous cycle.
  - Deaths are still latched if grace=000.
  - Releasing pause resumes from the held count.
- OVER: no move_en or collision_en; outputs hold.

Test Plan (TICK_DIV=4, COUNTDOWN_TICKS=3, GRACE_TICKS=2; start sampled high at cycle 0):
- Nominal start:
  - state=1 and round_rst=1 at cycle 1 only.
  - state=2 at cycle 13.
  - move_en=111 at cycles 16, 20, 24…
  - collision_en at cycles 17, 21.
  - grace=111 over cycles 13–20, 000 from cycle 21.
- boost=010: move_en[1] additionally pulses at cycles 14, 18, 22; collision_en follows each pulse by one cycle.
- Grace: dead=001 at cycle 18 -> alive stays 111. Same at cycle 22 -> alive=110 at cycle 23, and move_en[0] never pulses after that.
- Simultaneous deaths: dead=011 at cycle 22 -> alive=100, state=3, winner=3. dead=111 instead -> winner=0.
- Pause and restart:
  - pause=1 over cycles 15–30 -> no move_en; resume gives the next pulse at cycle 32.
  - start in OVER -> alive=111, winner=0, round_rst pulse.
- Async reset: reset=0 mid-RUN (between clock edges) -> all outputs at reset values immediately; state=0.
